// File: rtl/wb_regfile.sv
// wb_regfile: MIPS writeback stage -- writeback mux, 32 x DATA_W register file,
// two async read ports and a retired-write counter. Optional bypass: WB_REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_to_reg_i,
    input  logic              reg_write_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [4:0]        write_reg_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [4:0]        rs_addr_i,
    input  logic [4:0]        rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_valid_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_MEM  = 2'b01,
        SEL_PC   = 2'b10,
        SEL_RSVD = 2'b11
    } wb_sel_e;

    wb_sel_e           sel;
    logic [DATA_W-1:0] regs [32];

    assign sel = wb_sel_e'(mem_to_reg_i);

    always_comb begin
        wb_data_o = '0;
        case (sel)
            SEL_ALU: wb_data_o = alu_result_i;
            SEL_MEM: wb_data_o = read_data_i;
            SEL_PC:  wb_data_o = pc_i;
            default: wb_data_o = '0;
        endcase
    end

    assign wb_valid_o = rst & reg_write_i & (write_reg_i != 5'd0) & (sel != SEL_RSVD);

    // Entry 0 is cleared on reset and never written, so it always holds zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs         <= '{default: '0};
            retire_cnt_o <= '0;
        end else if (wb_valid_o) begin
            regs[write_reg_i] <= wb_data_o;
            retire_cnt_o      <= retire_cnt_o + CNT_W'(1);
        end
    end

    always_comb begin
        rs_data_o = '0;
        rt_data_o = '0;
        if (rst) begin
            if (rs_addr_i != 5'd0) rs_data_o = regs[rs_addr_i];
            if (rt_addr_i != 5'd0) rt_data_o = regs[rt_addr_i];
`ifdef WB_REGFILE_BYPASS_EN
            // wb_valid_o already excludes index 0, so r0 is never bypassed.
            if (wb_valid_o && rs_addr_i == write_reg_i) rs_data_o = wb_data_o;
            if (wb_valid_o && rt_addr_i == write_reg_i) rt_data_o = wb_data_o;
`endif
        end
    end

endmodule
